// File: rtl/baud_tick_gen_if.sv
// Control and status bundle between a UART core (master) and its baud-rate timebase (slave).
interface baud_tick_gen_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
);
  logic                    Enable;
  logic [2:0]              BaudSel;
  logic [DIV_W+FRAC_W-1:0] CustomDiv;
  logic                    Load;
  logic                    LoadAck;
  logic                    RxTick;
  logic                    TxTick;
  logic                    BaudOut;
  logic                    DivErr;

  modport master (
    output Enable, BaudSel, CustomDiv, Load,
    input  LoadAck, RxTick, TxTick, BaudOut, DivErr
  );

  modport slave (
    input  Enable, BaudSel, CustomDiv, Load,
    output LoadAck, RxTick, TxTick, BaudOut, DivErr
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional-divisor baud timebase: oversampling RxTick, bit-rate TxTick and BaudOut,
// with rate changes deferred to the next bit boundary.
module baud_tick_gen #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned DIV_W      = 16,
  parameter logic [2:0]  RESET_SEL  = 3'b010
) (
  input logic            Clock,
  input logic            ResetN,
  baud_tick_gen_if.slave bus
);

  localparam int unsigned     DW   = DIV_W + FRAC_W;
  localparam int unsigned     AW   = DW + 1;
  localparam int unsigned     OS_W = $clog2(OVERSAMPLE);
  localparam longint unsigned ONE  = 64'd1 << FRAC_W;

  typedef logic [DW-1:0]   div_t;
  typedef logic [AW-1:0]   acc_t;
  typedef logic [OS_W-1:0] os_t;

  typedef enum logic [2:0] {
    SEL_2400   = 3'd0,
    SEL_4800   = 3'd1,
    SEL_9600   = 3'd2,
    SEL_19200  = 3'd3,
    SEL_38400  = 3'd4,
    SEL_57600  = 3'd5,
    SEL_115200 = 3'd6,
    SEL_CUSTOM = 3'd7
  } baud_sel_e;

  // Rounded clocks-per-RxTick in fixed point, evaluated at elaboration only.
  function automatic div_t rate_div(input longint unsigned baud);
    longint unsigned num;
    longint unsigned den;
    num = 64'(CLK_HZ) * ONE * 64'd2;
    den = baud * 64'(OVERSAMPLE);
    return div_t'((num / den + 64'd1) / 64'd2);
  endfunction

  localparam div_t DIV_2400   = rate_div(2400);
  localparam div_t DIV_4800   = rate_div(4800);
  localparam div_t DIV_9600   = rate_div(9600);
  localparam div_t DIV_19200  = rate_div(19200);
  localparam div_t DIV_38400  = rate_div(38400);
  localparam div_t DIV_57600  = rate_div(57600);
  localparam div_t DIV_115200 = rate_div(115200);

  localparam div_t MIN_DIV = div_t'(2 * ONE);
  localparam acc_t ONE_ACC = acc_t'(ONE);
  localparam os_t  OS_LAST = os_t'(OVERSAMPLE - 1);

  function automatic div_t table_div(input baud_sel_e sel);
    case (sel)
      SEL_2400:   return DIV_2400;
      SEL_4800:   return DIV_4800;
      SEL_9600:   return DIV_9600;
      SEL_19200:  return DIV_19200;
      SEL_38400:  return DIV_38400;
      SEL_57600:  return DIV_57600;
      SEL_115200: return DIV_115200;
      default:    return '0;
    endcase
  endfunction

  localparam div_t RESET_DIV = table_div(baud_sel_e'(RESET_SEL));

  div_t div_q,      div_d;
  acc_t acc_q,      acc_d;
  os_t  os_cnt_q,   os_cnt_d;
  div_t pend_div_q, pend_div_d;
  logic pending_q,  pending_d;
  logic rx_tick_q,  rx_tick_d;
  logic tx_tick_q,  tx_tick_d;
  logic load_ack_q, load_ack_d;

  div_t sel_div;
  acc_t acc_next;
  logic div_err;
  logic rx_fire;
  logic tx_fire;

  assign div_err  = (div_q < MIN_DIV);
  assign acc_next = acc_q + ONE_ACC;
  assign rx_fire  = bus.Enable && !div_err && (acc_next >= acc_t'(div_q));
  assign tx_fire  = rx_fire && (os_cnt_q == OS_LAST);

  always_comb begin
    if (baud_sel_e'(bus.BaudSel) == SEL_CUSTOM) begin
      sel_div = bus.CustomDiv;
    end else begin
      sel_div = table_div(baud_sel_e'(bus.BaudSel));
    end
  end

  always_comb begin
    // NOTE: every variable gets its default first, so no path through this block can infer a latch.
    div_d      = div_q;
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    rx_tick_d  = 1'b0;
    tx_tick_d  = 1'b0;
    load_ack_d = 1'b0;

    // Phase accumulation: one ONE per clock, one Div removed per RxTick.
    if (!bus.Enable || div_err) begin
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (rx_fire) begin
      acc_d     = acc_next - acc_t'(div_q);
      os_cnt_d  = os_cnt_q + os_t'(1);
      rx_tick_d = 1'b1;
      tx_tick_d = tx_fire;
    end else begin
      acc_d = acc_next;
    end

    // A pending divisor waits for a bit boundary unless the timebase is idle or stalled.
    if (pending_q && (!bus.Enable || div_err || tx_fire)) begin
      div_d      = pend_div_q;
      acc_d      = '0;
      os_cnt_d   = '0;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end

    // A Load on an apply edge is kept for the following boundary.
    if (bus.Load) begin
      pend_div_d = sel_div;
      pending_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      div_q      <= RESET_DIV;
      acc_q      <= '0;
      os_cnt_q   <= '0;
      pend_div_q <= '0;
      pending_q  <= 1'b0;
      rx_tick_q  <= 1'b0;
      tx_tick_q  <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      rx_tick_q  <= rx_tick_d;
      tx_tick_q  <= tx_tick_d;
      load_ack_q <= load_ack_d;
    end
  end

  assign bus.RxTick  = rx_tick_q;
  assign bus.TxTick  = tx_tick_q;
  assign bus.BaudOut = os_cnt_q[OS_W-1];
  assign bus.LoadAck = load_ack_q;
  assign bus.DivErr  = div_err;

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate timebase for the UART Tx and Rx paths. It generates a 1-cycle oversampling tick (RxTick) and a 1-cycle bit tick (TxTick) from a fractional (fixed-point) divisor. The divisor comes from a built-in table of standard rates or from a runtime custom value. Rate changes are glitch-free and take effect only on a bit boundary; it replaces the fixed 4-rate toggle generator.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, RxTicks per bit; power of two, 4..16.
- FRAC_W, 4, fractional bits of the divisor; ONE = 2^FRAC_W.
- DIV_W, 16, integer bits of the divisor.
- RESET_SEL, 3'b010, BaudSel code active after reset (9600).
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Enable  in  1  run when high; when low: synchronous clear of the phase accumulator and OsCnt, and ticks are held at 0.
- BaudSel  in  3  rate code: 000 2400, 001 4800, 010 9600, 011 19200, 100 38400, 101 57600, 110 115200, 111 custom.
- CustomDiv  in  DIV_W+FRAC_W  clocks per RxTick, unsigned fixed point; used when BaudSel=111.
- Load  in  1  1-cycle strobe that captures BaudSel/CustomDiv.
- LoadAck  out  1  1-cycle pulse when the captured divisor becomes active.
- RxTick  out  1  1-cycle pulse at OVERSAMPLE × baud.
- TxTick  out  1  1-cycle pulse at the baud rate; always coincides with an RxTick.
- BaudOut  out  1  bit-rate square wave, equal to MSB of OsCnt.
- DivErr  out  1  high while the active divisor is < 2.0; ticks are suppressed.

## Operation
- **Table entries.** Computed at elaboration as round(CLK_HZ·ONE/(baud·OVERSAMPLE)). With the defaults: 9600 → 5208 (325.5 clocks); 115200 → 434 (27.125 clocks).
- **Registers.**
  - Div: active divisor, DIV_W+FRAC_W bits.
  - Acc: phase accumulator, DIV_W+FRAC_W+1 bits.
  - OsCnt: oversample counter, log2(OVERSAMPLE) bits.
  - PendDiv / Pending: captured divisor and its valid flag.
- **Accumulator, every enabled cycle with DivErr=0.**
  - next = Acc + ONE.
  - If next ≥ Div: Acc ← next − Div, RxTick ← 1, OsCnt ← OsCnt+1 (wraps).
  - Otherwise: Acc ← next, RxTick ← 0.
  - Result: average RxTick period is exactly Div/ONE clocks; each individual interval is floor or ceil of that.
- **TxTick.** TxTick ← 1 on the RxTick where OsCnt = OVERSAMPLE−1 before the increment.
- **BaudOut.** Low for the first half of the bit and high for the second half; its falling edge occurs in the same cycle as TxTick.
- **Load.**
  - A Load pulse resolves BaudSel (table entry or CustomDiv) into PendDiv and sets Pending.
  - A new Load while Pending is set overwrites PendDiv.
- **Apply, while Pending is set.**
  - Enable=1: apply on the edge that generates TxTick. Div ← PendDiv, Acc ← 0, OsCnt ← 0 (wrap), Pending ← 0; LoadAck is high in the same cycle as TxTick.
  - Enable=0 or DivErr=1: apply on the next edge; LoadAck is high the following cycle.
  - Load coincident with a TxTick-generating edge: captured, and applied at the next bit boundary, not the current one.
- **DivErr.** DivErr = (Div < 2·ONE), combinational from Div.
  - While set: Acc and OsCnt are held at 0, and RxTick, TxTick and BaudOut are 0.
  - It clears when a valid divisor is loaded.
- **Enable deassert.** Outputs drop to 0 on the next edge. Div and Pending are retained.

## Timing
- **Reset values.** Div = table[RESET_SEL], Acc = 0, OsCnt = 0, Pending = 0. Outputs RxTick, TxTick, BaudOut and LoadAck are 0. DivErr is 0 for any valid RESET_SEL.
- **Registered outputs.** All outputs are registered except DivErr.
- **First ticks, integer divisor N·ONE.**
  - The first RxTick is high in the cycle after the Nth enabled rising edge; subsequent RxTicks come every N cycles.
  - The first TxTick comes N·OVERSAMPLE cycles after Enable is first sampled high.
- **Reset mid-operation.** Asserting ResetN low at any time immediately forces the reset values, with no wait for a clock edge. A pending load is discarded.
- **No simultaneous-tick hazard.** Acc subtracts at most one Div per cycle because Div ≥ 2·ONE is guaranteed when ticking.

## Test plan
- **Reset.** Pulse ResetN low while the block is running → all outputs 0 immediately. After release, Div = 5208 and DivErr = 0.
- **Integer custom divisor.** Enable=0, BaudSel=111, CustomDiv=64 (4.0), Load → LoadAck 1 cycle later. Then Enable=1 → RxTick every 4 cycles, TxTick every 64 cycles, BaudOut 32 cycles low / 32 cycles high.
- **Fractional divisor.** CustomDiv=40 (2.5) → RxTick intervals alternate 2 and 3 cycles; exactly 16 RxTicks and 1 TxTick per 40 cycles.
- **Mid-operation load.** Running at 4.0, Load CustomDiv=128 (8.0) 10 cycles after a TxTick → 4-cycle spacing continues until the next TxTick. LoadAck coincides with that TxTick; RxTick spacing is 8 cycles thereafter.
- **Invalid divisor.** Load CustomDiv=24 (1.5) → DivErr=1 and no ticks over 100 cycles. Load BaudSel=110 → DivErr=0 and 16 RxTicks per 434 cycles (27.125 average).
- **Overwrite and coincidence.** Two Loads before a bit boundary → only the second is applied, with a single LoadAck. A Load on a TxTick edge → applied one bit later.
